alu_share_arbiter: RTL and testbench

//  Shares one combinational ALU (S/T/Ctr in, Result out) between two requesters,
//  e.g. the execute stage and an address/branch-compare unit. Round-robin

---
 rtl/alu_share_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one external combinational ALU between two requesters. Selection is
//   round-robin, ALU operands are registered and the result is registered.
//   Only one operation is in flight at a time: IDLE -> EXEC -> RESP -> IDLE.
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   req{0,1}_valid/ready            request handshake (ready is combinational)
//   req{0,1}_ctr/_s/_t              ALU control code and operands per requester
//   rsp{0,1}_valid/ready/_result    response handshake and result per requester
//   alu_s, alu_t, alu_ctr           registered operands/control to the ALU
//   alu_result                      combinational ALU result
//   busy                            high while an operation is in EXEC or RESP
//   op_count                        completed responses, wraps modulo 2^CNT_W
module alu_share_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTR_W  = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTR_W-1:0]  req0_ctr,
  input  logic [DATA_W-1:0] req0_s,
  input  logic [DATA_W-1:0] req0_t,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTR_W-1:0]  req1_ctr,
  input  logic [DATA_W-1:0] req1_s,
  input  logic [DATA_W-1:0] req1_t,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic [DATA_W-1:0] alu_s,
  output logic [DATA_W-1:0] alu_t,
  output logic [CTR_W-1:0]  alu_ctr,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              ptr;        // requester favoured when both are valid
  logic              owner;      // requester of the operation in flight
  logic [DATA_W-1:0] result_q;
  logic              grant_valid;
  logic              grant;
  logic              accept;
  logic              rsp_take;

  // Round-robin choice between the currently valid requesters.
  always_comb begin
    grant_valid = 1'b0;
    grant       = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant       = ptr;
    end else if (req0_valid) begin
      grant_valid = 1'b1;
      grant       = 1'b0;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant       = 1'b1;
    end
  end

  // Next state and handshake outputs. Ready is suppressed while reset is
  // asserted so nothing appears accepted in a cycle that gets discarded.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    rsp_take   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        accept     = grant_valid && !reset;
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
        if (accept) state_nxt = EXEC;
      end
      EXEC: begin
        busy      = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        busy       = 1'b1;
        rsp0_valid = !owner;
        rsp1_valid = owner;
        rsp_take   = owner ? rsp1_ready : rsp0_ready;
        if (rsp_take) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp0_result = result_q;
  assign rsp1_result = result_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      owner    <= 1'b0;
      result_q <= '0;
      alu_s    <= '0;
      alu_t    <= '0;
      alu_ctr  <= '0;
      op_count <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner   <= grant;
        alu_s   <= grant ? req1_s   : req0_s;
        alu_t   <= grant ? req1_t   : req0_t;
        alu_ctr <= grant ? req1_ctr : req0_ctr;
      end
      if (state == EXEC) result_q <= alu_result;
      if (rsp_take) begin
        op_count <= op_count + CNT_W'(1);
        ptr      <= ~owner;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Directed bench for alu_share_arbiter with a behavioural ALU attached.
//   The counter is built 4 bits wide so its wrap point is reachable quickly.
module tb_alu_share_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 3;
  localparam int unsigned NW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [CW-1:0] req0_ctr, req1_ctr, alu_ctr;
  logic [DW-1:0] req0_s, req0_t, req1_s, req1_t;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DW-1:0] rsp0_result, rsp1_result, alu_s, alu_t, alu_result;
  logic          busy;
  logic [NW-1:0] op_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(DW), .CTR_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctr(req0_ctr),
    .req0_s(req0_s), .req0_t(req0_t),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctr(req1_ctr),
    .req1_s(req1_s), .req1_t(req1_t),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .alu_s(alu_s), .alu_t(alu_t), .alu_ctr(alu_ctr), .alu_result(alu_result),
    .busy(busy), .op_count(op_count)
  );

  // Behavioural ALU: 1 add, 2 sub, 3 and, 4 or, 5 slt, 6 eq, others 0.
  always_comb begin
    alu_result = '0;
    case (alu_ctr)
      3'd1: alu_result = alu_s + alu_t;
      3'd2: alu_result = alu_s - alu_t;
      3'd3: alu_result = alu_s & alu_t;
      3'd4: alu_result = alu_s | alu_t;
      3'd5: alu_result = {31'd0, $signed(alu_s) < $signed(alu_t)};
      3'd6: alu_result = {31'd0, alu_s == alu_t};
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction from a single requester with the response taken
  // immediately. Called at posedge+1 with the arbiter in IDLE.
  task automatic do_op(input logic who, input logic [CW-1:0] ctr,
                       input logic [DW-1:0] s, input logic [DW-1:0] t,
                       input logic [DW-1:0] exp);
    int n = 0;
    if (who) begin
      req1_valid = 1'b1; req1_ctr = ctr; req1_s = s; req1_t = t; rsp1_ready = 1'b1;
    end else begin
      req0_valid = 1'b1; req0_ctr = ctr; req0_s = s; req0_t = t; rsp0_ready = 1'b1;
    end
    #1;
    while (!(who ? req1_ready : req0_ready) && n < 8) begin
      tick(); #1; n++;
    end
    check("op_ready", who ? req1_ready : req0_ready, 1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("op_alu_ctr", alu_ctr, ctr);
    tick();
    check("op_rsp_valid", who ? rsp1_valid : rsp0_valid, 1);
    check("op_rsp_result", who ? rsp1_result : rsp0_result, exp);
    tick();
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req0_valid = 1'b1; req0_ctr = '0; req0_s = '0; req0_t = '0;
    req1_valid = 1'b0; req1_ctr = '0; req1_s = '0; req1_t = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    tick(); tick();
    check("rst_req0_ready", req0_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_op_count", op_count, 0);
    check("rst_alu_s", alu_s, 0);
    check("rst_alu_ctr", alu_ctr, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    req0_valid = 1'b0;
    reset = 1'b0;
    tick();

    // 1: single add 5+7 from requester 0
    req0_valid = 1'b1; req0_ctr = 3'd1; req0_s = 5; req0_t = 7;
    #1;
    check("t1_req0_ready", req0_ready, 1);
    check("t1_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0; req0_s = 99;
    check("t1_alu_ctr", alu_ctr, 1);
    check("t1_alu_s", alu_s, 5);
    check("t1_alu_t", alu_t, 7);
    check("t1_busy", busy, 1);
    check("t1_rsp0_early", rsp0_valid, 0);
    tick();
    check("t1_rsp0_valid", rsp0_valid, 1);
    check("t1_rsp0_result", rsp0_result, 12);
    check("t1_rsp1_valid", rsp1_valid, 0);
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    check("t1_rsp0_done", rsp0_valid, 0);
    check("t1_op_count", op_count, 1);
    check("t1_idle", busy, 0);

    // 2: both requesters valid every cycle, alternation from requester 0
    reset = 1'b1; tick(); reset = 1'b0;
    req0_valid = 1'b1; req0_ctr = 3'd2; req0_s = 10;    req0_t = 3;
    req1_valid = 1'b1; req1_ctr = 3'd3; req1_s = 'hF0; req1_t = 'h3C;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_grant0", req0_ready, (i % 2) == 0);
      check("t2_grant1", req1_ready, (i % 2) == 1);
      tick(); tick();
      if (i % 2 == 0) begin
        check("t2_rsp0_valid", rsp0_valid, 1);
        check("t2_rsp0_result", rsp0_result, 7);
      end else begin
        check("t2_rsp1_valid", rsp1_valid, 1);
        check("t2_rsp1_result", rsp1_result, 'h30);
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    check("t2_op_count", op_count, 4);

    // 3: response held off for five cycles, slt -1 < 0
    req1_valid = 1'b1; req1_ctr = 3'd5; req1_s = 32'hFFFF_FFFF; req1_t = 0;
    #1;
    check("t3_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    tick();
    req0_valid = 1'b1; req0_ctr = 3'd1; req0_s = 1; req0_t = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3_rsp1_valid", rsp1_valid, 1);
      check("t3_rsp1_result", rsp1_result, 1);
      check("t3_no_accept", req0_ready, 0);
      tick();
    end
    rsp1_ready = 1'b1;
    tick();
    rsp1_ready = 1'b0;
    #1;
    check("t3_rsp1_done", rsp1_valid, 0);
    check("t3_req0_ready", req0_ready, 1);
    check("t3_op_count", op_count, 5);
    req0_valid = 1'b0;
    tick();

    // 4: reset during EXEC after the pointer has moved to requester 1
    do_op(1'b0, 3'd1, 2, 3, 5);
    check("t4_op_count_pre", op_count, 6);
    req1_valid = 1'b1; req1_ctr = 3'd2; req1_s = 9; req1_t = 4;
    #1;
    check("t4_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    check("t4_in_exec", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4_rsp0_valid", rsp0_valid, 0);
    check("t4_rsp1_valid", rsp1_valid, 0);
    check("t4_busy", busy, 0);
    check("t4_op_count", op_count, 0);
    check("t4_alu_s", alu_s, 0);
    tick();
    check("t4_rsp1_still_low", rsp1_valid, 0);
    req0_valid = 1'b1; req0_ctr = 3'd1; req0_s = 1; req0_t = 1;
    req1_valid = 1'b1; req1_ctr = 3'd4; req1_s = 1; req1_t = 2;
    #1;
    check("t4_ptr_grant0", req0_ready, 1);
    check("t4_ptr_grant1", req1_ready, 0);

    // 6: requester 1 valid for a single busy cycle, then dropped
    tick();
    req0_valid = 1'b0;
    check("t6_req1_busy_ready", req1_ready, 0);
    tick();
    req1_valid = 1'b0;
    check("t6_rsp0_valid", rsp0_valid, 1);
    check("t6_rsp0_result", rsp0_result, 2);
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t6_no_rsp1", rsp1_valid, 0);
      check("t6_idle", busy, 0);
      tick();
    end
    check("t6_op_count", op_count, 1);

    // 5: counter wrap; operands also exercise ALU wrap-around
    for (int i = 0; i < 14; i++)
      do_op(i[0], 3'd1, 32'hFFFF_FFFF, DW'(i + 1), DW'(i));
    check("t5_op_count_max", op_count, 15);
    do_op(1'b0, 3'd7, 1, 1, 0);
    check("t5_op_count_wrap", op_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
